fifo_demux3: RTL and testbench
==============================

Name: fifo_demux3

Overview:
- Inverse of the three-channel merge path. Takes the single tagged stream on clk_d (data, valid, 2-bit channel tag) and steers each word to one of three per-channel buffers (channels 0/1/2).
- Each buffer drains through a valid/ready handshake towards the channel consumers.
- All logic is in the clk_d domain; clock crossing to consumer clocks sits downstream and is out of scope.
- Words that cannot be stored are dropped and counted.

Parameters:
- DW, 16, data width of input and output words.
- DEPTH, 8, entries per channel buffer; power of two, minimum 2.
- AW, 3, log2(DEPTH); pointer width.
- CW, 8, width of each saturating drop counter.

Ports:
- clk_d  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- data_d  input  DW  input word
- data_d_vld  input  1  input word valid, one word per cycle, no backpressure
- chan_d  input  2  destination tag: 0=ch0, 1=ch1, 2=ch2, 3=invalid
- dout0 / dout1 / dout2  output  DW each  channel head word
- dout0_vld / dout1_vld / dout2_vld  output  1 each  channel head valid
- dout0_rdy / dout1_rdy / dout2_rdy  input  1 each  consumer accepts head
- full  output  3  per-channel buffer full flags, bit n = channel n
- drop_cnt  output  3*CW  per-channel overflow drop counts; ch0 in [CW-1:0]
- bad_chan_cnt  output  CW  count of valid words tagged chan_d==3

Behaviour:
- Reset (rst_n low, async):
  - all pointers and counts to 0
  - doutN_vld=0, doutN=0, full=0, drop_cnt=0, bad_chan_cnt=0
  - in-flight words are discarded
- Channel buffer: circular RAM, DEPTH entries, wr_ptr/rd_ptr of AW bits wrapping modulo DEPTH, occupancy count of AW+1 bits.
- Write:
  - Occurs when data_d_vld=1, chan_d=n (n<3) and count_n<DEPTH, judged on the pre-edge count.
  - A write to a full buffer is dropped even if the same-cycle read frees a slot. drop_cnt[n] increments, saturating at 2^CW-1.
- Invalid tag: data_d_vld=1 with chan_d=3 writes nothing; bad_chan_cnt increments, saturating.
- data_d_vld=0: chan_d and data_d are ignored.
- Read (first-word-fall-through):
  - doutN_vld is a registered flag, 1 whenever count_n>0; doutN presents RAM[rd_ptr] (registered head).
  - Handshake completes on a cycle with doutN_vld=1 and doutN_rdy=1; rd_ptr advances and the next word (if any) appears the following cycle.
  - doutN and doutN_vld stay stable while vld=1 and rdy=0.
  - rdy while vld=0 has no effect.
- Latency: a word written on edge k to an empty buffer shows doutN_vld=1 with that data after edge k+1 (one cycle).
- Simultaneous write and read on the same channel with 0<count<DEPTH: count unchanged, both pointers advance.
- Write to a full buffer together with a read: read proceeds, write dropped, count becomes DEPTH-1.
- Ordering: strict FIFO order per channel. No ordering relation across channels.
- full[n] is registered and equals (count_n==DEPTH) after each edge.
- Channels are fully independent; backpressure on one never affects another.

Test Plan:
1. Reset, then write 0x1111 to ch0, 0x2222 to ch1, 0x3333 to ch2 on consecutive cycles, all rdy=1 -> each doutN_vld pulses for one cycle, one cycle after its write, with matching data; drop_cnt=0.
2. dout1_rdy=0; write 10 words 0x0100..0x0109 to ch1 -> full[1]=1 after the 8th, drop_cnt[ch1]=2; release rdy -> 0x0100..0x0107 emerge in order, full[1] clears after the first read.
3. ch2 full with rdy=1; write 0xABCD to ch2 on the same cycle as a read -> write dropped, drop_cnt[ch2]=1, count=7.
4. Valid words with chan_d=3 on 3 cycles, plus one cycle with chan_d=3 and vld=0 -> bad_chan_cnt=3; no doutN_vld activity.
5. Random interleaved tags over 200 words, random per-channel rdy -> scoreboard per-channel order and data. Every input word is either delivered or counted in drop_cnt/bad_chan_cnt; totals match.
6. Assert rst_n low mid-stream with 5 words buffered in ch0 -> dout0_vld=0 immediately (async); after release, no stale words appear; counters are 0.

Source files
------------

// File: rtl/fifo_demux3_if.sv
// Bundle of the tagged input stream and the three channel output handshakes
// for fifo_demux3. "master" is the side that feeds words and consumes the
// channel heads; "slave" is the demultiplexer itself.
interface fifo_demux3_if #(
    parameter int DW = 16,
    parameter int CW = 8
);
    logic [DW-1:0]   data_d;
    logic            data_d_vld;
    logic [1:0]      chan_d;

    logic [DW-1:0]   dout0;
    logic [DW-1:0]   dout1;
    logic [DW-1:0]   dout2;
    logic            dout0_vld;
    logic            dout1_vld;
    logic            dout2_vld;
    logic            dout0_rdy;
    logic            dout1_rdy;
    logic            dout2_rdy;

    logic [2:0]      full;
    logic [3*CW-1:0] drop_cnt;
    logic [CW-1:0]   bad_chan_cnt;

    modport master (
        output data_d, data_d_vld, chan_d,
        output dout0_rdy, dout1_rdy, dout2_rdy,
        input  dout0, dout1, dout2,
        input  dout0_vld, dout1_vld, dout2_vld,
        input  full, drop_cnt, bad_chan_cnt
    );

    modport slave (
        input  data_d, data_d_vld, chan_d,
        input  dout0_rdy, dout1_rdy, dout2_rdy,
        output dout0, dout1, dout2,
        output dout0_vld, dout1_vld, dout2_vld,
        output full, drop_cnt, bad_chan_cnt
    );
endinterface

// File: rtl/fifo_demux3.sv
// Three-way demultiplexer: steers a tagged input stream into three independent
// circular buffers, each drained first-word-fall-through with a registered head.
// Words arriving for a full buffer, or tagged 3, are dropped and counted.
module fifo_demux3 #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 8
) (
    input  logic          clk_d,
    input  logic          rst_n,
    fifo_demux3_if.slave  bus
);

    logic [2:0]      rdy_vec;
    logic [2:0]      vld_vec;
    logic [2:0]      full_vec;
    logic [3*CW-1:0] drop_vec;
    logic [DW-1:0]   head_arr [3];
    logic [CW-1:0]   bad_reg;

    assign rdy_vec          = {bus.dout2_rdy, bus.dout1_rdy, bus.dout0_rdy};
    assign bus.dout0        = head_arr[0];
    assign bus.dout1        = head_arr[1];
    assign bus.dout2        = head_arr[2];
    assign bus.dout0_vld    = vld_vec[0];
    assign bus.dout1_vld    = vld_vec[1];
    assign bus.dout2_vld    = vld_vec[2];
    assign bus.full         = full_vec;
    assign bus.drop_cnt     = drop_vec;
    assign bus.bad_chan_cnt = bad_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_chan
            logic [DW-1:0] ram [DEPTH];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [AW-1:0] rd_ptr_next;
            logic [AW:0]   count_reg;
            logic [AW:0]   count_after_rd;
            logic [AW:0]   count_next;
            logic          wr_req;
            logic          wr_en;
            logic          drop_en;
            logic          rd_en;
            logic          vld_reg;
            logic          full_reg;
            logic [DW-1:0] head_reg;
            logic [CW-1:0] drop_reg;

            // Accept/drop decision uses the pre-edge occupancy, so a same-cycle
            // read never rescues a write into a full buffer.
            always_comb begin
                wr_req         = bus.data_d_vld && (bus.chan_d == 2'(gi));
                wr_en          = wr_req && (count_reg != (AW+1)'(DEPTH));
                drop_en        = wr_req && (count_reg == (AW+1)'(DEPTH));
                rd_en          = vld_reg && rdy_vec[gi];
                count_after_rd = count_reg - (AW+1)'(rd_en);
                count_next     = count_after_rd + (AW+1)'(wr_en);
                rd_ptr_next    = rd_ptr_reg + AW'(rd_en);
            end

            // Pointer, occupancy and status flags. The head becomes valid only
            // for words already in RAM before this edge (one-cycle fall-through).
            always_ff @(posedge clk_d or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    vld_reg    <= 1'b0;
                    full_reg   <= 1'b0;
                    drop_reg   <= '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_next;
                    vld_reg    <= (count_after_rd != '0);
                    full_reg   <= (count_next == (AW+1)'(DEPTH));
                    if (drop_en && (drop_reg != '1)) begin
                        drop_reg <= drop_reg + CW'(1);
                    end
                end
            end

            // Buffer storage, no reset so it maps onto block RAM.
            always_ff @(posedge clk_d) begin
                if (wr_en) begin
                    ram[wr_ptr_reg] <= bus.data_d;
                end
            end

            // Registered head read; addressing with the post-read pointer keeps
            // the head stable while stalled and presents the next word after a pop.
            always_ff @(posedge clk_d or negedge rst_n) begin
                if (!rst_n) begin
                    head_reg <= '0;
                end else begin
                    head_reg <= ram[rd_ptr_next];
                end
            end

            assign head_arr[gi]            = head_reg;
            assign vld_vec[gi]             = vld_reg;
            assign full_vec[gi]            = full_reg;
            assign drop_vec[gi*CW +: CW]   = drop_reg;
        end
    endgenerate

    // Saturating count of valid words carrying the unused tag 3.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            bad_reg <= '0;
        end else if (bus.data_d_vld && (bus.chan_d == 2'd3) && (bad_reg != '1)) begin
            bad_reg <= bad_reg + CW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_demux3.sv
// Self-checking bench for fifo_demux3: directed scenarios plus a randomized
// run checked against a queue-based per-channel reference model.
module tb_fifo_demux3;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 8;

    logic          clk_d = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_vld;
    logic [1:0]    din_chan;
    logic [2:0]    rdy;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_demux3_if #(.DW(DW), .CW(CW)) bus ();

    fifo_demux3 #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk_d (clk_d),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_d = ~clk_d;

    assign bus.data_d     = din;
    assign bus.data_d_vld = din_vld;
    assign bus.chan_d     = din_chan;
    assign bus.dout0_rdy  = rdy[0];
    assign bus.dout1_rdy  = rdy[1];
    assign bus.dout2_rdy  = rdy[2];

    logic [2:0]    dvld;
    logic [DW-1:0] ddat [3];
    assign dvld    = {bus.dout2_vld, bus.dout1_vld, bus.dout0_vld};
    assign ddat[0] = bus.dout0;
    assign ddat[1] = bus.dout1;
    assign ddat[2] = bus.dout2;

    function automatic logic [CW-1:0] drop_of(input int ch);
        return bus.drop_cnt[ch*CW +: CW];
    endfunction

    task automatic drive(input logic v, input logic [1:0] c, input logic [DW-1:0] d);
        din_vld  = v;
        din_chan = c;
        din      = d;
    endtask

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, '0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_d);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd0, '0);
        rdy   = 3'b000;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_d);
        n_tests++;
        if (dvld !== 3'b000 || bus.full !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags vld=%b full=%b required 000/000", dvld, bus.full);
        end
        n_tests++;
        if (ddat[0] !== '0 || ddat[1] !== '0 || ddat[2] !== '0) begin
            n_fail++;
            $display("FAIL reset_dout got %h %h %h required 0", ddat[0], ddat[1], ddat[2]);
        end
        n_tests++;
        if (bus.drop_cnt !== '0 || bus.bad_chan_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters drop=%h bad=%h required 0", bus.drop_cnt, bus.bad_chan_cnt);
        end
        rst_n = 1'b1;
        tick();
        $display("[TB] test_reset done");
    endtask

    // One word to each channel; each head pulses for one cycle, one cycle after its write.
    task automatic test_single();
        logic [DW-1:0] vals [3];
        logic [2:0]    exp_vld;
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        rdy = 3'b111;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 2'(i), vals[i]);
            else       drive(1'b0, 2'd0, '0);
            tick();
            exp_vld = (i >= 1 && i <= 3) ? 3'(1 << (i - 1)) : 3'b000;
            n_tests++;
            if (dvld !== exp_vld) begin
                n_fail++;
                $display("FAIL single_vld step %0d got %b required %b", i, dvld, exp_vld);
            end
            if (exp_vld != 3'b000) begin
                n_tests++;
                if (ddat[i-1] !== vals[i-1]) begin
                    n_fail++;
                    $display("FAIL single_data ch%0d got %h required %h", i - 1, ddat[i-1], vals[i-1]);
                end
            end
        end
        n_tests++;
        if (bus.drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL single_drop got %h required 0", bus.drop_cnt);
        end
        $display("[TB] test_single done");
    endtask

    // Fill ch1 while stalled, overflow by two, then drain in order.
    task automatic test_fill_drop();
        rdy = 3'b101;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd1, 16'h0100 + 16'(i));
            tick();
            n_tests++;
            if (bus.full[1] !== (i >= 7)) begin
                n_fail++;
                $display("FAIL fill_full word %0d got %b required %b", i, bus.full[1], (i >= 7));
            end
        end
        drive(1'b0, 2'd0, '0);
        tick();
        n_tests++;
        if (drop_of(1) !== 8'd2) begin
            n_fail++;
            $display("FAIL fill_drop ch1 got %0d required 2", drop_of(1));
        end
        rdy = 3'b111;
        for (int j = 0; j < DEPTH; j++) begin
            n_tests++;
            if (dvld[1] !== 1'b1 || ddat[1] !== 16'h0100 + 16'(j)) begin
                n_fail++;
                $display("FAIL fill_drain %0d got vld=%b data=%h required 1/%h", j, dvld[1], ddat[1], 16'h0100 + 16'(j));
            end
            tick();
            if (j == 0) begin
                n_tests++;
                if (bus.full[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_full_clear got %b required 0", bus.full[1]);
                end
            end
        end
        n_tests++;
        if (dvld[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_empty got vld=%b required 0", dvld[1]);
        end
        $display("[TB] test_fill_drop done");
    endtask

    // Write into full ch2 on the same cycle as a read: write is dropped.
    task automatic test_full_rw();
        rdy = 3'b011;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 2'd2, 16'h0200 + 16'(i));
            tick();
        end
        drive(1'b0, 2'd0, '0);
        tick();
        n_tests++;
        if (bus.full[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL fullrw_full got %b required 1", bus.full[2]);
        end
        rdy = 3'b111;
        drive(1'b1, 2'd2, 16'hABCD);
        tick();
        drive(1'b0, 2'd0, '0);
        n_tests++;
        if (drop_of(2) !== 8'd1 || bus.full[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL fullrw_drop got drop=%0d full=%b required 1/0", drop_of(2), bus.full[2]);
        end
        for (int j = 1; j < DEPTH; j++) begin
            n_tests++;
            if (dvld[2] !== 1'b1 || ddat[2] !== 16'h0200 + 16'(j)) begin
                n_fail++;
                $display("FAIL fullrw_drain %0d got vld=%b data=%h required 1/%h", j, dvld[2], ddat[2], 16'h0200 + 16'(j));
            end
            tick();
        end
        n_tests++;
        if (dvld[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL fullrw_leftover got vld=%b data=%h required empty", dvld[2], ddat[2]);
        end
        $display("[TB] test_full_rw done");
    endtask

    // Tag 3 words are counted and never reach a channel.
    task automatic test_bad_chan();
        rdy = 3'b111;
        for (int i = 0; i < 4; i++) begin
            drive((i != 2), 2'd3, 16'hBAD0 + 16'(i));
            tick();
            n_tests++;
            if (dvld !== 3'b000) begin
                n_fail++;
                $display("FAIL bad_vld step %0d got %b required 000", i, dvld);
            end
        end
        drive(1'b0, 2'd3, '0);
        tick();
        n_tests++;
        if (bus.bad_chan_cnt !== 8'd3 || dvld !== 3'b000) begin
            n_fail++;
            $display("FAIL bad_count got %0d vld=%b required 3/000", bus.bad_chan_cnt, dvld);
        end
        $display("[TB] test_bad_chan done");
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            edge_no;
    } ent_t;

    // Randomized traffic against a queue model: a word is stored iff its
    // queue held fewer than DEPTH words before the edge, and becomes visible
    // once at least one further edge has passed.
    task automatic test_random();
        ent_t          mq [3][$];
        logic [2:0]    m_vld;
        int            m_drop [3];
        int            m_bad;
        int            edge_no;
        int            sent;
        int            delivered;
        int            total;
        int            cyc;
        int            size_pre;
        ent_t          e;
        do_reset();
        m_vld   = 3'b000;
        m_bad   = 0;
        edge_no = 0;
        sent    = 0;
        delivered = 0;
        for (int c = 0; c < 3; c++) m_drop[c] = 0;
        cyc = 0;
        while (cyc < 2000 && (sent < 200 || cyc < 0 || mq[0].size() + mq[1].size() + mq[2].size() != 0 || m_vld != 3'b000)) begin
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (dvld[c] !== m_vld[c]) begin
                    n_fail++;
                    $display("FAIL rand_vld cyc %0d ch%0d got %b required %b", cyc, c, dvld[c], m_vld[c]);
                end else if (m_vld[c]) begin
                    n_tests++;
                    if (ddat[c] !== mq[c][0].data) begin
                        n_fail++;
                        $display("FAIL rand_data cyc %0d ch%0d got %h required %h", cyc, c, ddat[c], mq[c][0].data);
                    end
                end
                n_tests++;
                if (bus.full[c] !== (mq[c].size() == DEPTH) || drop_of(c) !== CW'(m_drop[c])) begin
                    n_fail++;
                    $display("FAIL rand_status cyc %0d ch%0d full=%b drop=%0d required %b/%0d",
                             cyc, c, bus.full[c], drop_of(c), (mq[c].size() == DEPTH), m_drop[c]);
                end
            end
            n_tests++;
            if (bus.bad_chan_cnt !== CW'(m_bad)) begin
                n_fail++;
                $display("FAIL rand_bad cyc %0d got %0d required %0d", cyc, bus.bad_chan_cnt, m_bad);
            end
            if (sent < 200) begin
                drive(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), DW'($urandom));
                rdy = 3'($urandom);
            end else begin
                drive(1'b0, 2'd0, '0);
                rdy = 3'b111;
            end
            if (din_vld) sent++;
            for (int c = 0; c < 3; c++) if (dvld[c] && rdy[c]) delivered++;
            @(posedge clk_d);
            edge_no++;
            if (din_vld && din_chan == 2'd3) m_bad++;
            for (int c = 0; c < 3; c++) begin
                size_pre = mq[c].size();
                if (m_vld[c] && rdy[c]) void'(mq[c].pop_front());
                if (din_vld && din_chan == 2'(c)) begin
                    if (size_pre < DEPTH) begin
                        e.data    = din;
                        e.edge_no = edge_no;
                        mq[c].push_back(e);
                    end else begin
                        m_drop[c]++;
                    end
                end
                m_vld[c] = (mq[c].size() > 0) && (mq[c][0].edge_no < edge_no);
            end
            #1;
            cyc++;
        end
        n_tests++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL rand_timeout cycles %0d required < 2000", cyc);
        end
        total = delivered + int'(drop_of(0)) + int'(drop_of(1)) + int'(drop_of(2)) + int'(bus.bad_chan_cnt);
        n_tests++;
        if (total != sent) begin
            n_fail++;
            $display("FAIL rand_totals accounted %0d required %0d", total, sent);
        end
        $display("[TB] test_random done: sent %0d delivered %0d", sent, delivered);
    endtask

    // Asynchronous reset while ch0 holds 5 words.
    task automatic test_async_reset();
        rdy = 3'b110;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, 16'h5000 + 16'(i));
            tick();
        end
        drive(1'b0, 2'd0, '0);
        tick();
        n_tests++;
        if (dvld[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre got vld=%b required 1", dvld[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dvld !== 3'b000 || bus.full !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_immediate vld=%b full=%b required 000/000", dvld, bus.full);
        end
        n_tests++;
        if (bus.drop_cnt !== '0 || bus.bad_chan_cnt !== '0) begin
            n_fail++;
            $display("FAIL areset_counters drop=%h bad=%h required 0", bus.drop_cnt, bus.bad_chan_cnt);
        end
        repeat (2) @(negedge clk_d);
        rst_n = 1'b1;
        rdy   = 3'b111;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (dvld !== 3'b000) begin
                n_fail++;
                $display("FAIL areset_stale cyc %0d got vld=%b required 000", i, dvld);
            end
        end
        n_tests++;
        if (bus.drop_cnt !== '0 || bus.bad_chan_cnt !== '0 || bus.full !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_after drop=%h bad=%h full=%b required 0", bus.drop_cnt, bus.bad_chan_cnt, bus.full);
        end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 3'b000;
        drive(1'b0, 2'd0, '0);
        test_reset();
        test_single();
        test_fill_drop();
        test_full_rw();
        test_bad_chan();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
